sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Parametrised sprite renderer for the VGA pixel path.
- Draws one frame of an animated, multi-frame indexed-colour sprite at a programmable screen position, with integer power-of-two scaling, optional horizontal flip and a transparent colour index.
- Pixels outside the sprite, or transparent pixels, pass the background RGB through.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour output. It drives an external synchronous sprite ROM and an external combinational palette.

Parameters:
- SPRITE_W, 50, sprite width in texels.
- SPRITE_H, 50, sprite height in texels.
- NUM_FRAMES, 4, number of animation frames stored consecutively in the ROM.
- IDX_W, 2, palette index width (ROM data width).
- ADDR_W, 14, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H*NUM_FRAMES.
- TRANSP_IDX, 0, palette index treated as transparent.
- FRAME_DIV, 8, number of frame_tick pulses per animation step (>=1).

Ports:
- vga_clk, input, 1, pixel clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-high.
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- blank, input, 1, 1 = active display region.
- frame_tick, input, 1, one-cycle pulse once per frame at vertical blank start.
- anim_en, input, 1, 1 = animation advances.
- pos_x, input, 10, sprite top-left column, sampled on frame_tick.
- pos_y, input, 10, sprite top-left row, sampled on frame_tick.
- scale_sh, input, 2, scale factor 2^scale_sh, sampled on frame_tick.
- flip_h, input, 1, horizontal mirror, sampled on frame_tick.
- bg_rgb, input, 12, background colour {r,g,b} for the current DrawX/DrawY.
- rom_addr, output, ADDR_W, registered ROM address.
- rom_q, input, IDX_W, ROM data; valid one cycle after rom_addr.
- pal_index, output, IDX_W, equals the registered rom_q sample.
- pal_rgb, input, 12, palette colour for pal_index (combinational).
- red, output, 4, pixel red.
- green, output, 4, pixel green.
- blue, output, 4, pixel blue.
- frame_idx, output, clog2(NUM_FRAMES), current animation frame.

Behaviour:
- Reset (async, active-high) clears:
  - red/green/blue, rom_addr, pal_index, frame_idx and the frame_tick divider to 0;
  - shadow pos_x/pos_y/scale_sh/flip_h to 0;
  - all pipeline valid/hit/blank bits to 0.
- Shadow registers: pos_x, pos_y, scale_sh and flip_h load only in the cycle frame_tick=1. Between ticks, input changes are ignored, so there is no tearing mid-frame.
- Stage 0 (cycle t), combinational, 11-bit unsigned arithmetic, no wrap:
  - dx = DrawX - sx, dy = DrawY - sy (sx/sy = shadow position).
  - hit = DrawX >= sx and dx < (SPRITE_W << sh) and DrawY >= sy and dy < (SPRITE_H << sh).
  - lx = dx >> sh; ly = dy >> sh.
  - If flip, lx = SPRITE_W-1-lx.
  - addr = frame_idx*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx.
  - When hit=0, addr is don't-care; hold the previous value.
  - A sprite extending past column 639 or row 479 is clipped, never wrapped.
- Stage 1 (t+1): rom_addr registered; hit and blank delayed; bg_rgb delayed.
- Stage 2 (t+2): rom_q valid; pal_index <= rom_q; hit, blank and bg delayed again.
- Stage 3 (t+3): output register:
  - delayed blank=0 -> RGB = 0.
  - Else hit=1 and pal_index != TRANSP_IDX -> RGB = pal_rgb.
  - Else -> RGB = delayed bg_rgb.
- Total latency is 3 cycles from DrawX/DrawY/bg_rgb/blank to RGB, fixed, with no bubbles.
- Animation:
  - The divider counts frame_tick pulses only while anim_en=1.
  - When divider = FRAME_DIV-1 and a tick occurs: divider -> 0, frame_idx -> (frame_idx+1) mod NUM_FRAMES.
  - anim_en=0 freezes both divider and frame_idx.
- frame_idx updates on the tick cycle; the new frame is used from the following cycle, i.e. within vertical blank.
- A shadow-register load and a frame advance on the same tick are both applied.
- Reset mid-line: outputs 0 immediately. After release, first valid RGB appears 3 cycles later; pipeline bits are 0 until refilled.

Test Plan:
- Reset asserted mid-frame -> RGB=0 and frame_idx=0 asynchronously; rom_addr=0.
- pos=(100,50), scale_sh=0, flip=0, frame 0, DrawX=100, DrawY=50, blank=1 -> rom_addr=0 at t+1; RGB=pal_rgb of index rom_q[0] at t+3.
- Same setup, DrawX=149, DrawY=99 -> rom_addr=2499; DrawX=150 -> hit=0, RGB=bg_rgb at t+3.
- scale_sh=1, flip=1, DrawX=100+2*3=106, DrawY=50 -> lx=49-3=46, rom_addr=46; frame_idx=2 -> rom_addr=5046.
- ROM returns TRANSP_IDX=0 inside sprite with bg_rgb=12'hABC -> RGB=A,B,C. blank=0 inside sprite -> RGB=0.
- FRAME_DIV=8, NUM_FRAMES=4, anim_en=1, 32 ticks -> frame_idx steps 0,1,2,3 every 8 ticks, then 0. anim_en=0 for 5 ticks -> frame_idx unchanged. pos_x changed mid-frame -> sprite position changes only after next tick.

Source files
------------

// File: rtl/sprite_blitter.sv
// sprite_blitter: animated indexed-colour sprite overlay for the VGA pixel path.
// Fixed 3-cycle latency from DrawX/DrawY/bg_rgb/blank to the RGB outputs.
module sprite_blitter #(
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 50,
    parameter int NUM_FRAMES = 4,
    parameter int IDX_W      = 2,
    parameter int ADDR_W     = 14,
    parameter int TRANSP_IDX = 0,
    parameter int FRAME_DIV  = 8,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic              anim_en,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        scale_sh,
    input  logic              flip_h,
    input  logic [11:0]       bg_rgb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [FW-1:0]     frame_idx
);

    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef struct packed {
        logic        hit;
        logic        blank;
        logic [11:0] bg;
    } pix_t;

    logic [9:0]        sx_q, sx_d, sy_q, sy_d;
    logic [1:0]        sh_q, sh_d;
    logic              flip_q, flip_d;
    logic [DW-1:0]     div_q, div_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    pix_t              s1_q, s1_d, s2_q, s2_d;
    logic [11:0]       rgb_q, rgb_d;

    logic [10:0] dx, dy, lx, ly;
    logic [12:0] ext_x, ext_y;
    logic        hit0;

    // Shadow registers load only on frame_tick; animation divider and frame step.
    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        sh_d    = sh_q;
        flip_d  = flip_q;
        div_d   = div_q;
        frame_d = frame_q;
        if (frame_tick) begin
            sx_d   = pos_x;
            sy_d   = pos_y;
            sh_d   = scale_sh;
            flip_d = flip_h;
        end
        if (frame_tick && anim_en) begin
            if (div_q == DW'(FRAME_DIV - 1)) begin
                div_d   = '0;
                frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Stage 0: hit test and texel address; 11-bit offsets so the sprite clips, never wraps.
    always_comb begin
        dx    = {1'b0, DrawX} - {1'b0, sx_q};
        dy    = {1'b0, DrawY} - {1'b0, sy_q};
        ext_x = 13'(SPRITE_W) << sh_q;
        ext_y = 13'(SPRITE_H) << sh_q;
        hit0  = (DrawX >= sx_q) && ({2'b00, dx} < ext_x) &&
                (DrawY >= sy_q) && ({2'b00, dy} < ext_y);
        lx    = dx >> sh_q;
        ly    = dy >> sh_q;
        if (flip_q) begin
            lx = 11'(SPRITE_W - 1) - lx;
        end
        rom_addr_d = rom_addr_q;
        if (hit0) begin
            rom_addr_d = ADDR_W'(32'(frame_q) * 32'(SPRITE_W * SPRITE_H) +
                                 32'(ly) * 32'(SPRITE_W) + 32'(lx));
        end
    end

    // The ROM's output register is the index sample; masked so idle/reset cycles read 0.
    assign pal_index = rom_q & {IDX_W{s2_q.hit}};

    // Stages 1-3: delay hit/blank/bg alongside the ROM read, then pick the pixel colour.
    always_comb begin
        s1_d.hit   = hit0;
        s1_d.blank = blank;
        s1_d.bg    = bg_rgb;
        s2_d       = s1_q;
        if (!s2_q.blank) begin
            rgb_d = '0;
        end else if (s2_q.hit && (pal_index != IDX_W'(TRANSP_IDX))) begin
            rgb_d = pal_rgb;
        end else begin
            rgb_d = s2_q.bg;
        end
    end

    // All state, cleared asynchronously.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sx_q       <= '0;
            sy_q       <= '0;
            sh_q       <= '0;
            flip_q     <= 1'b0;
            div_q      <= '0;
            frame_q    <= '0;
            rom_addr_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            rgb_q      <= '0;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            sh_q       <= sh_d;
            flip_q     <= flip_d;
            div_q      <= div_d;
            frame_q    <= frame_d;
            rom_addr_q <= rom_addr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr            = rom_addr_q;
    assign {red, green, blue}  = rgb_q;
    assign frame_idx           = frame_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized bench for sprite_blitter with an arithmetic
// reference model, a ROM/palette model and a 3-deep expected-colour queue.
module tb_sprite_blitter;

    localparam int W  = 50;
    localparam int H  = 50;
    localparam int NF = 4;
    localparam int IW = 2;
    localparam int AW = 14;
    localparam int FD = 8;
    localparam int FW = 2;

    logic          vga_clk = 1'b0;
    logic          reset;
    logic [9:0]    DrawX, DrawY, pos_x, pos_y;
    logic          blank, frame_tick, anim_en, flip_h;
    logic [1:0]    scale_sh;
    logic [11:0]   bg_rgb, pal_rgb, rgb;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_q, pal_index;
    logic [3:0]    red, green, blue;
    logic [FW-1:0] frame_idx;

    logic [IW-1:0] rom_mem [W*H*NF];
    logic [11:0]   pal [4];

    int checks = 0;
    int errors = 0;

    int m_sx, m_sy, m_sh, m_fl, m_frame, m_div, m_addr;
    logic [11:0] expq [$];
    logic [11:0] exp_rgb;
    bit          have_exp;

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk)
        rom_q <= (int'(rom_addr) < W*H*NF) ? rom_mem[rom_addr] : '0;

    assign pal_rgb = pal[pal_index];
    assign rgb     = {red, green, blue};

    sprite_blitter dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_tick(frame_tick), .anim_en(anim_en),
        .pos_x(pos_x), .pos_y(pos_y), .scale_sh(scale_sh), .flip_h(flip_h),
        .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_index(pal_index), .pal_rgb(pal_rgb), .red(red), .green(green),
        .blue(blue), .frame_idx(frame_idx)
    );

    // Reference geometry: rectangle test, integer division by the scale, mirror.
    function automatic bit model_hit(input int x, input int y, output int a);
        int s, col, row;
        s = 1 << m_sh;
        a = 0;
        if (x < m_sx || x >= m_sx + W*s || y < m_sy || y >= m_sy + H*s)
            return 1'b0;
        col = (x - m_sx) / s;
        row = (y - m_sy) / s;
        if (m_fl != 0) col = W - 1 - col;
        a = m_frame*W*H + row*W + col;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_sh = 0; m_fl = 0;
        m_frame = 0; m_div = 0; m_addr = 0;
        expq.delete();
        expq.push_back(12'h000);
        expq.push_back(12'h000);
    endtask

    task automatic step(input int x, input int y, input bit bl,
                        input logic [11:0] bg, input bit tick);
        int a;
        bit h;
        logic [11:0] e;
        DrawX = 10'(x); DrawY = 10'(y); blank = bl; bg_rgb = bg;
        frame_tick = tick;
        h = model_hit(x, y, a);
        if (h) m_addr = a;
        if (!bl) e = 12'h000;
        else if (h && rom_mem[a] != 0) e = pal[rom_mem[a]];
        else e = bg;
        expq.push_back(e);
        if (tick) begin
            m_sx = int'(pos_x); m_sy = int'(pos_y);
            m_sh = int'(scale_sh); m_fl = int'(flip_h);
            if (anim_en) begin
                if (m_div == FD-1) begin
                    m_div = 0;
                    m_frame = (m_frame + 1) % NF;
                end else begin
                    m_div++;
                end
            end
        end
        @(posedge vga_clk); #1;
        frame_tick = 1'b0;
        have_exp = 1'b0;
        if (expq.size() == 3) begin
            exp_rgb = expq.pop_front();
            have_exp = 1'b1;
        end
    endtask

    task automatic load(input int x, input int y, input int sh, input bit fl);
        pos_x = 10'(x); pos_y = 10'(y); scale_sh = 2'(sh); flip_h = fl;
        step(0, 0, 1'b0, 12'h000, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks += 3;
        if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
        if (frame_idx !== 0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", frame_idx); end
        if (rom_addr !== 0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        @(posedge vga_clk); #1;
        reset = 1'b0;
        model_reset();
        anim_en = 1'b1;
        for (int i = 0; i < 9; i++) load(100, 50, 0, 1'b0);
        anim_en = 1'b0;
        for (int i = 0; i < 6; i++) step(101 + i, 50, 1'b1, 12'h123, 1'b0);
        reset = 1'b1;
        #2;
        checks += 3;
        if (rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb: got %h expected 000", rgb); end
        if (frame_idx !== 0) begin errors++; $display("FAIL midreset_frame: got %0d expected 0", frame_idx); end
        if (rom_addr !== 0) begin errors++; $display("FAIL midreset_addr: got %0d expected 0", rom_addr); end
        @(posedge vga_clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1'b1, 12'h5A5, 1'b0);
            if (have_exp) begin
                checks++;
                if (rgb !== exp_rgb) begin errors++; $display("FAIL refill_rgb: got %h expected %h", rgb, exp_rgb); end
            end
        end
    endtask

    task automatic test_basic();
        int xs [4] = '{100, 101, 149, 150};
        int ys [4] = '{50, 50, 99, 99};
        int ea [4] = '{0, 1, 2499, 2499};
        load(100, 50, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(xs[i], ys[i], 1'b1, 12'(i * 273 + 7), 1'b0);
            else step(0, 0, 1'b0, 12'h000, 1'b0);
            if (i < 4) begin
                checks++;
                if (rom_addr !== AW'(ea[i])) begin errors++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, rom_addr, ea[i]); end
            end
            if (have_exp) begin
                checks++;
                if (rgb !== exp_rgb) begin errors++; $display("FAIL basic_rgb: got %h expected %h", rgb, exp_rgb); end
            end
        end
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(90, 160), $urandom_range(40, 110),
                 $urandom_range(0, 7) != 0, 12'($urandom), 1'b0);
            checks++;
            if (rom_addr !== AW'(m_addr)) begin errors++; $display("FAIL basic_rand_addr: got %0d expected %0d", rom_addr, m_addr); end
            if (have_exp) begin
                checks++;
                if (rgb !== exp_rgb) begin errors++; $display("FAIL basic_rand_rgb: got %h expected %h", rgb, exp_rgb); end
            end
        end
    endtask

    task automatic test_scale_flip();
        load(100, 50, 1, 1'b1);
        step(106, 50, 1'b1, 12'h0F0, 1'b0);
        checks++;
        if (rom_addr !== 14'd46) begin errors++; $display("FAIL flip_addr: got %0d expected 46", rom_addr); end
        anim_en = 1'b1;
        for (int i = 0; i < 16; i++) load(100, 50, 1, 1'b1);
        anim_en = 1'b0;
        checks++;
        if (frame_idx !== 2'd2) begin errors++; $display("FAIL flip_frame: got %0d expected 2", frame_idx); end
        step(106, 50, 1'b1, 12'h0F0, 1'b0);
        checks++;
        if (rom_addr !== 14'd5046) begin errors++; $display("FAIL flip_addr_f2: got %0d expected 5046", rom_addr); end
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(90, 210), $urandom_range(40, 160),
                 $urandom_range(0, 7) != 0, 12'($urandom), 1'b0);
            checks++;
            if (rom_addr !== AW'(m_addr)) begin errors++; $display("FAIL flip_rand_addr: got %0d expected %0d", rom_addr, m_addr); end
            if (have_exp) begin
                checks++;
                if (rgb !== exp_rgb) begin errors++; $display("FAIL flip_rand_rgb: got %h expected %h", rgb, exp_rgb); end
            end
        end
    endtask

    task automatic test_transparent();
        load(100, 50, 0, 1'b0);
        step(100, 50, 1'b1, 12'hABC, 1'b0);
        step(0, 0, 1'b0, 12'h000, 1'b0);
        step(0, 0, 1'b0, 12'h000, 1'b0);
        checks++;
        if (rgb !== 12'hABC) begin errors++; $display("FAIL transp_rgb: got %h expected abc", rgb); end
        step(101, 50, 1'b0, 12'hABC, 1'b0);
        step(0, 0, 1'b0, 12'h000, 1'b0);
        step(0, 0, 1'b0, 12'h000, 1'b0);
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL blank_rgb: got %h expected 000", rgb); end
    endtask

    task automatic test_anim();
        int want;
        reset = 1'b1;
        @(posedge vga_clk); #1;
        reset = 1'b0;
        model_reset();
        anim_en = 1'b1;
        for (int i = 0; i < 44; i++) begin
            load(0, 0, 0, 1'b0);
            want = ((i + 1) / FD) % NF;
            checks++;
            if (frame_idx !== FW'(want)) begin errors++; $display("FAIL anim_step%0d: got %0d expected %0d", i, frame_idx, want); end
        end
        anim_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load(0, 0, 0, 1'b0);
            checks++;
            if (frame_idx !== 2'd1) begin errors++; $display("FAIL anim_freeze: got %0d expected 1", frame_idx); end
        end
        anim_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(0, 0, 0, 1'b0);
            want = (i == 3) ? 2 : 1;
            checks++;
            if (frame_idx !== FW'(want)) begin errors++; $display("FAIL anim_resume%0d: got %0d expected %0d", i, frame_idx, want); end
        end
        anim_en = 1'b0;
    endtask

    task automatic test_shadow();
        load(200, 100, 0, 1'b0);
        step(201, 100, 1'b1, 12'h321, 1'b0);
        checks++;
        if (rom_addr !== AW'(2*W*H + 1)) begin errors++; $display("FAIL shadow_addr0: got %0d expected %0d", rom_addr, 2*W*H + 1); end
        pos_x = 10'd300;
        step(300, 100, 1'b1, 12'h321, 1'b0);
        checks++;
        if (rom_addr !== AW'(2*W*H + 1)) begin errors++; $display("FAIL shadow_hold: got %0d expected %0d", rom_addr, 2*W*H + 1); end
        step(0, 0, 1'b0, 12'h000, 1'b1);
        step(302, 100, 1'b1, 12'h321, 1'b0);
        checks++;
        if (rom_addr !== AW'(2*W*H + 2)) begin errors++; $display("FAIL shadow_moved: got %0d expected %0d", rom_addr, 2*W*H + 2); end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1'b0, 12'h000, 1'b0);
            checks++;
            if (rgb !== exp_rgb) begin errors++; $display("FAIL shadow_rgb: got %h expected %h", rgb, exp_rgb); end
        end
    endtask

    task automatic test_back_to_back();
        int s, x, y;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                anim_en = 1'($urandom_range(0, 1));
                pos_x = 10'($urandom_range(0, 700));
                pos_y = 10'($urandom_range(0, 500));
                scale_sh = 2'($urandom);
                flip_h = 1'($urandom);
                step(0, 0, 1'b0, 12'h000, 1'b1);
            end else begin
                s = 1 << m_sh;
                x = m_sx + $urandom_range(0, W*s + 20) - 10;
                y = m_sy + $urandom_range(0, H*s + 20) - 10;
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                step(x, y, $urandom_range(0, 7) != 0, 12'($urandom), 1'b0);
            end
            checks++;
            if (rom_addr !== AW'(m_addr)) begin errors++; $display("FAIL b2b_addr: got %0d expected %0d", rom_addr, m_addr); end
            checks++;
            if (frame_idx !== FW'(m_frame)) begin errors++; $display("FAIL b2b_frame: got %0d expected %0d", frame_idx, m_frame); end
            if (have_exp) begin
                checks++;
                if (rgb !== exp_rgb) begin errors++; $display("FAIL b2b_rgb: got %h expected %h", rgb, exp_rgb); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < W*H*NF; i++) rom_mem[i] = IW'($urandom);
        for (int k = 0; k < NF; k++) rom_mem[k*W*H] = '0;
        rom_mem[1] = 2'd3;
        rom_mem[2*W*H + 1] = 2'd2;
        rom_mem[2*W*H + 2] = 2'd1;
        for (int i = 0; i < 4; i++) pal[i] = 12'($urandom);
        reset = 1'b1;
        DrawX = '0; DrawY = '0; blank = 1'b0; frame_tick = 1'b0;
        anim_en = 1'b0; pos_x = '0; pos_y = '0; scale_sh = '0;
        flip_h = 1'b0; bg_rgb = '0;
        model_reset();
        test_reset();
        test_basic();
        test_scale_flip();
        test_transparent();
        test_anim();
        test_shadow();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
